// File: rtl/cam_pixel_packer.sv
// Camera pixel packer: builds RGB565 pixels from an 8..16 bit DVP bus,
// crops to a window, drops frames on a skip ratio and flags odd-beat lines.
//
// Ports:
//   I_pxl_clk, I_rst_n       pixel clock, async active-low reset
//   I_vsync, I_href, I_data  camera sync and data (byte = top 8 bits)
//   I_en, I_mode, I_skip     capture controls, sampled at frame start
//   I_h_start, I_h_res       horizontal crop window (pixels)
//   I_v_start, I_v_res       vertical crop window (lines)
//   O_vs_n                   frame sync, low while a passed frame's VSYNC
//   O_de, O_data             pixel valid and RGB565 pixel
//   O_frame_cnt              passed-frame counter
//   O_sync_err               sticky odd-beat line error
module cam_pixel_packer #(
  parameter int IN_W   = 10,
  parameter int CNT_W  = 12,
  parameter int FCNT_W = 16
) (
  input  logic              I_pxl_clk,
  input  logic              I_rst_n,
  input  logic              I_vsync,
  input  logic              I_href,
  input  logic [IN_W-1:0]   I_data,
  input  logic              I_en,
  input  logic [1:0]        I_mode,
  input  logic [3:0]        I_skip,
  input  logic [CNT_W-1:0]  I_h_start,
  input  logic [CNT_W-1:0]  I_h_res,
  input  logic [CNT_W-1:0]  I_v_start,
  input  logic [CNT_W-1:0]  I_v_res,
  output logic              O_vs_n,
  output logic              O_de,
  output logic [15:0]       O_data,
  output logic [FCNT_W-1:0] O_frame_cnt,
  output logic              O_sync_err
);

  // edge-detect history
  logic              r_vs_d;
  logic              r_href_d;

  // per-frame settings
  logic [1:0]        r_mode;
  logic [CNT_W-1:0]  r_h_start;
  logic [CNT_W-1:0]  r_h_res;
  logic [CNT_W-1:0]  r_v_start;
  logic [CNT_W-1:0]  r_v_res;
  logic              r_pass;
  logic [3:0]        r_skip_cnt;

  // beat assembly and position
  logic              r_phase;
  logic [7:0]        r_a_byte;
  logic [CNT_W-1:0]  r_x;
  logic [CNT_W-1:0]  r_y;

  // output registers
  logic              r_vs_n;
  logic              r_de;
  logic [15:0]       r_data;
  logic [FCNT_W-1:0] r_frame_cnt;
  logic              r_sync_err;

  logic              w_fs;
  logic              w_hfall;
  logic              w_beat;
  logic              w_pass_new;
  logic [3:0]        w_skip_nxt;
  logic              w_two_beat;
  logic              w_swap;
  logic              w_form;
  logic [7:0]        w_byte;
  logic [5:0]        w_grey;
  logic [15:0]       w_pix;
  logic [CNT_W:0]    w_x_end;
  logic [CNT_W:0]    w_y_end;
  logic              w_in_x;
  logic              w_in_y;
  logic              w_emit;
  logic              w_x_max;
  logic              w_y_max;
  logic [IN_W-1:0]   w_unused_data;

  // low-order data bits below the byte lane carry no pixel content
  assign w_unused_data = I_data;

  assign w_fs    = I_vsync & ~r_vs_d;
  assign w_hfall = r_href_d & ~I_href;
  assign w_beat  = I_href & ~I_vsync;

  // skip_cnt==0 with capture enabled passes the frame
  assign w_pass_new = (r_skip_cnt == 4'd0) & I_en;

  always_comb begin
    w_skip_nxt = r_skip_cnt;
    if (w_pass_new) begin
      w_skip_nxt = I_skip;
    end else if (r_skip_cnt != 4'd0) begin
      w_skip_nxt = r_skip_cnt - 4'd1;
    end
  end

  // modes 0 and 2 pair two beats; 1 and 3 are one beat per pixel
  assign w_two_beat = ~r_mode[0];
  assign w_swap     = r_mode[1];

  assign w_byte = I_data[IN_W-1 -: 8];
  assign w_grey = I_data[IN_W-1 -: 6];

  assign w_form = w_beat & (~w_two_beat | r_phase);

  always_comb begin
    w_pix = r_data;
    unique case (1'b1)
      ~w_two_beat: begin
        w_pix = {w_grey[5:1], w_grey, w_grey[5:1]};
      end
      w_two_beat & w_swap: begin
        w_pix = {w_byte, r_a_byte};
      end
      w_two_beat & ~w_swap: begin
        w_pix = {r_a_byte, w_byte};
      end
      default: begin
        w_pix = r_data;
      end
    endcase
  end

  // one extra bit keeps start+res from wrapping
  assign w_x_end = {1'b0, r_h_start} + {1'b0, r_h_res};
  assign w_y_end = {1'b0, r_v_start} + {1'b0, r_v_res};

  assign w_in_x = (r_x >= r_h_start) &
                  ({1'b0, r_x} < w_x_end);
  assign w_in_y = (r_y >= r_v_start) &
                  ({1'b0, r_y} < w_y_end);

  assign w_emit = w_form & r_pass & w_in_x & w_in_y;

  assign w_x_max = (r_x == {CNT_W{1'b1}});
  assign w_y_max = (r_y == {CNT_W{1'b1}});

  // sync history
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_vs_d   <= 1'b0;
      r_href_d <= 1'b0;
    end else begin
      r_vs_d   <= I_vsync;
      r_href_d <= I_href;
    end
  end

  // frame-start sampling of settings and pass/drop decision
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_mode     <= 2'd0;
      r_h_start  <= '0;
      r_h_res    <= '0;
      r_v_start  <= '0;
      r_v_res    <= '0;
      r_pass     <= 1'b0;
      r_skip_cnt <= 4'd0;
    end else if (w_fs) begin
      r_mode     <= I_mode;
      r_h_start  <= I_h_start;
      r_h_res    <= I_h_res;
      r_v_start  <= I_v_start;
      r_v_res    <= I_v_res;
      r_pass     <= w_pass_new;
      r_skip_cnt <= w_skip_nxt;
    end
  end

  // beat phase and first-byte store
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_phase  <= 1'b0;
      r_a_byte <= 8'd0;
    end else begin
      if (w_fs || !I_href) begin
        r_phase <= 1'b0;
      end else if (w_beat && w_two_beat) begin
        r_phase <= ~r_phase;
      end
      if (w_beat && w_two_beat && !r_phase) begin
        r_a_byte <= w_byte;
      end
    end
  end

  // position counters, saturating
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else begin
      if (w_fs || w_hfall) begin
        r_x <= '0;
      end else if (w_form && !w_x_max) begin
        r_x <= r_x + CNT_W'(1);
      end
      if (w_fs) begin
        r_y <= '0;
      end else if (w_hfall && !w_y_max) begin
        r_y <= r_y + CNT_W'(1);
      end
    end
  end

  // frame sync, frame counter and sticky error
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_vs_n      <= 1'b1;
      r_frame_cnt <= '0;
      r_sync_err  <= 1'b0;
    end else begin
      r_vs_n <= ~(I_vsync & (w_fs ? w_pass_new : r_pass));
      if (w_fs && w_pass_new) begin
        r_frame_cnt <= r_frame_cnt + FCNT_W'(1);
      end
      // a half pixel at line end is dropped; only the flag records it
      if (w_fs && w_pass_new) begin
        r_sync_err <= 1'b0;
      end else if (w_hfall && w_two_beat && r_phase) begin
        r_sync_err <= 1'b1;
      end
    end
  end

  // pixel output
  always_ff @(posedge I_pxl_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_de   <= 1'b0;
      r_data <= 16'd0;
    end else begin
      r_de <= w_emit;
      if (w_emit) begin
        r_data <= w_pix;
      end
    end
  end

  assign O_vs_n      = r_vs_n;
  assign O_de        = r_de;
  assign O_data      = r_data;
  assign O_frame_cnt = r_frame_cnt;
  assign O_sync_err  = r_sync_err;

endmodule

// File: tb/tb_cam_pixel_packer.sv
// Bench for cam_pixel_packer: frame/line-level expected-pixel queue
// checked every cycle, plus literal checks per scenario.
module tb_cam_pixel_packer;

  localparam int IN_W   = 10;
  localparam int CNT_W  = 12;
  localparam int FCNT_W = 16;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic              vsync = 1'b0;
  logic              href  = 1'b0;
  logic [IN_W-1:0]   data  = '0;
  logic              en    = 1'b0;
  logic [1:0]        mode  = 2'd0;
  logic [3:0]        skip  = 4'd0;
  logic [CNT_W-1:0]  hs    = '0;
  logic [CNT_W-1:0]  hr    = '0;
  logic [CNT_W-1:0]  vs    = '0;
  logic [CNT_W-1:0]  vr    = '0;

  logic              o_vs_n;
  logic              o_de;
  logic [15:0]       o_data;
  logic [FCNT_W-1:0] o_fcnt;
  logic              o_err;

  cam_pixel_packer #(
    .IN_W(IN_W), .CNT_W(CNT_W), .FCNT_W(FCNT_W)
  ) dut (
    .I_pxl_clk  (clk),
    .I_rst_n    (rst_n),
    .I_vsync    (vsync),
    .I_href     (href),
    .I_data     (data),
    .I_en       (en),
    .I_mode     (mode),
    .I_skip     (skip),
    .I_h_start  (hs),
    .I_h_res    (hr),
    .I_v_start  (vs),
    .I_v_res    (vr),
    .O_vs_n     (o_vs_n),
    .O_de       (o_de),
    .O_data     (o_data),
    .O_frame_cnt(o_fcnt),
    .O_sync_err (o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] px;
  } exp_t;

  exp_t q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int de_cnt  = 0;
  logic [15:0] last_de = '0;
  bit vs_low_seen = 1'b0;

  bit              m_pass = 1'b0;
  int              m_skip = 0;
  logic [FCNT_W-1:0] m_fcnt = '0;
  bit              m_err  = 1'b0;
  logic [15:0]     m_data = '0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h",
               nm, act, want);
    end
  endtask

  function automatic logic [15:0] grey_px(
    input logic [IN_W-1:0] v);
    logic [5:0] p;
    p = v[IN_W-1 -: 6];
    return {p[5:1], p, p[5:1]};
  endfunction

  // per-cycle compare against the model
  initial begin
    exp_t e;
    logic ev;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (o_de === 1'b1) begin
        de_cnt++;
        last_de = o_data;
      end
      if (o_vs_n === 1'b0) vs_low_seen = 1'b1;
      ev = ~(vsync & m_pass);
      chk("vs_n", {31'd0, o_vs_n}, {31'd0, ev});
      if (o_de === 1'b1) begin
        if (q.size() == 0) begin
          chk("de_unexpected", {31'd0, o_de}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("de_cycle", cyc, e.cyc);
          chk("de_data", {16'd0, o_data}, {16'd0, e.px});
          m_data = e.px;
        end
      end else if (q.size() > 0 && q[0].cyc <= cyc) begin
        chk("de_missing", {31'd0, o_de}, 32'd1);
        void'(q.pop_front());
      end
      chk("data_hold", {16'd0, o_data}, {16'd0, m_data});
      chk("frame_cnt", {16'd0, o_fcnt}, {16'd0, m_fcnt});
      chk("sync_err", {31'd0, o_err}, {31'd0, m_err});
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    q.delete();
    m_pass = 1'b0;
    m_skip = 0;
    m_fcnt = '0;
    m_err  = 1'b0;
    m_data = '0;
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_vs_n"}, {31'd0, o_vs_n}, 32'd1);
    chk({nm, "_de"}, {31'd0, o_de}, 32'd0);
    chk({nm, "_data"}, {16'd0, o_data}, 32'd0);
    chk({nm, "_fcnt"}, {16'd0, o_fcnt}, 32'd0);
    chk({nm, "_err"}, {31'd0, o_err}, 32'd0);
  endtask

  // nl lines of nb beats; beat i = (i odd ? b : a) + i*inc.
  // glitch >= 0 rewrites I_mode mid-frame; rst_at pulses
  // reset on that beat of line 0.
  task automatic frame(input int nl, input int nb,
                       input logic [IN_W-1:0] a,
                       input logic [IN_W-1:0] b,
                       input logic [IN_W-1:0] inc,
                       input int glitch,
                       input int rst_at);
    logic [1:0]      lm;
    int              lhs, lhr, lvs, lvr;
    bit              two;
    bit              emit;
    int              x;
    logic [IN_W-1:0] v;
    logic [IN_W-1:0] va;
    logic [15:0]     px;
    @(negedge clk);
    lm  = mode;
    lhs = int'(hs);
    lhr = int'(hr);
    lvs = int'(vs);
    lvr = int'(vr);
    if (m_skip == 0 && en) begin
      m_pass = 1'b1;
      m_skip = int'(skip);
      m_fcnt = m_fcnt + 1'b1;
      m_err  = 1'b0;
    end else begin
      m_pass = 1'b0;
      if (m_skip > 0) m_skip--;
    end
    vs_low_seen = 1'b0;
    vsync = 1'b1;
    idle(3);
    vsync = 1'b0;
    if (glitch >= 0) mode = 2'(glitch);
    idle(2);
    two = (lm == 2'd0) || (lm == 2'd2);
    va = '0;
    for (int y = 0; y < nl; y++) begin
      for (int i = 0; i < nb; i++) begin
        @(negedge clk);
        v = (((i % 2) != 0) ? b : a) + IN_W'(i) * inc;
        href = 1'b1;
        data = v;
        emit = 1'b0;
        x = 0;
        px = '0;
        if (two) begin
          if ((i % 2) == 0) begin
            va = v;
          end else begin
            x = i / 2;
            emit = 1'b1;
            if (lm == 2'd0)
              px = {va[IN_W-1 -: 8], v[IN_W-1 -: 8]};
            else
              px = {v[IN_W-1 -: 8], va[IN_W-1 -: 8]};
          end
        end else begin
          x = i;
          emit = 1'b1;
          px = grey_px(v);
        end
        if (emit && m_pass &&
            x >= lhs && x < lhs + lhr &&
            y >= lvs && y < lvs + lvr)
          q.push_back('{cyc + 1, px});
        if (y == 0 && i == rst_at) begin
          #2;
          rst_n = 1'b0;
          model_reset();
          #1;
          chk_reset_vals("rst_mid");
        end
        if (y == 0 && rst_at >= 0 && i == rst_at + 2)
          rst_n = 1'b1;
      end
      @(negedge clk);
      href = 1'b0;
      if (two && (nb % 2) == 1) m_err = 1'b1;
      idle(2);
    end
    idle(2);
  endtask

  initial begin
    int d0;
    logic [FCNT_W-1:0] f0;
    bit pf;

    #12;
    chk_reset_vals("rst_init");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // a line before any frame start must not emit
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      href = 1'b1;
      data = 10'h3E0;
    end
    @(negedge clk);
    href = 1'b0;
    idle(3);
    chk("pre_fs_de", de_cnt, 0);

    // RGB565 two-beat
    mode = 2'd0; en = 1'b1; skip = 4'd0;
    hs = 12'd0; hr = 12'd4; vs = 12'd0; vr = 12'd2;
    d0 = de_cnt;
    frame(2, 8, 10'h3E0, 10'h07C, 10'h0, -1, -1);
    chk("m0_count", de_cnt - d0, 8);
    chk("m0_data", {16'd0, last_de}, 32'h0000F81F);
    chk("m0_fcnt", {16'd0, o_fcnt}, 32'd1);

    // byte-swapped
    mode = 2'd2;
    d0 = de_cnt;
    frame(2, 8, 10'h3E0, 10'h07C, 10'h0, -1, -1);
    chk("m2_count", de_cnt - d0, 8);
    chk("m2_data", {16'd0, last_de}, 32'h00001FF8);

    // grey, one beat per pixel
    mode = 2'd1;
    d0 = de_cnt;
    frame(2, 4, 10'h3FF, 10'h3FF, 10'h0, -1, -1);
    chk("m1_count", de_cnt - d0, 8);
    chk("m1_data", {16'd0, last_de}, 32'h0000FFFF);

    // zero-size windows
    mode = 2'd3; hr = 12'd0;
    d0 = de_cnt;
    frame(2, 4, 10'h155, 10'h2AA, 10'h0, -1, -1);
    chk("hres0_count", de_cnt - d0, 0);
    hr = 12'd4; vr = 12'd0;
    d0 = de_cnt;
    frame(2, 4, 10'h155, 10'h2AA, 10'h0, -1, -1);
    chk("vres0_count", de_cnt - d0, 0);
    vr = 12'd2;

    // frame skipping: pass 1 of every 3
    mode = 2'd0; skip = 4'd2;
    f0 = o_fcnt;
    for (int f = 0; f < 6; f++) begin
      pf = (f == 0) || (f == 3);
      d0 = de_cnt;
      frame(1, 4, 10'h3E0, 10'h07C, 10'h0, -1, -1);
      chk("skip_vs_low", {31'd0, vs_low_seen}, {31'd0, pf});
      chk("skip_de", de_cnt - d0, pf ? 2 : 0);
    end
    chk("skip_fcnt", {16'd0, o_fcnt - f0}, 32'd2);
    skip = 4'd0;

    // crop window 2/3/1/1 on 4 lines of 8 grey pixels
    mode = 2'd1;
    hs = 12'd2; hr = 12'd3; vs = 12'd1; vr = 12'd1;
    d0 = de_cnt;
    frame(4, 8, 10'h0, 10'h0, 10'h010, -1, -1);
    chk("crop_count", de_cnt - d0, 3);
    chk("crop_last", {16'd0, last_de}, 32'h00001082);

    // odd beat line; mode rewritten mid-frame is ignored
    mode = 2'd0;
    hs = 12'd0; hr = 12'd4; vs = 12'd0; vr = 12'd2;
    d0 = de_cnt;
    frame(1, 5, 10'h3E0, 10'h07C, 10'h0, 1, -1);
    chk("odd_count", de_cnt - d0, 2);
    chk("odd_err", {31'd0, o_err}, 32'd1);
    mode = 2'd0;
    d0 = de_cnt;
    frame(1, 4, 10'h3E0, 10'h07C, 10'h0, -1, -1);
    chk("odd_clr_err", {31'd0, o_err}, 32'd0);
    chk("odd_clr_count", de_cnt - d0, 2);

    // reset mid-line drops the rest of the frame
    d0 = de_cnt;
    frame(2, 8, 10'h3E0, 10'h07C, 10'h0, -1, 2);
    chk("rst_count", de_cnt - d0, 1);
    chk("rst_fcnt", {16'd0, o_fcnt}, 32'd0);
    d0 = de_cnt;
    frame(2, 8, 10'h3E0, 10'h07C, 10'h0, -1, -1);
    chk("post_rst_count", de_cnt - d0, 8);
    chk("post_rst_fcnt", {16'd0, o_fcnt}, 32'd1);

    idle(3);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cam_pixel_packer.md
CAM_PIXEL_PACKER -- requirements
Module: cam_pixel_packer

Interface
REQ-001 SHALL have parameter IN_W, default 10: camera data bus width, legal range 8..16.
REQ-002 SHALL have parameter CNT_W, default 12: width of crop and position counters.
REQ-003 SHALL have parameter FCNT_W, default 16: frame counter width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, as listed below.
REQ-005 SHALL have port I_pxl_clk, input, 1 bit: camera pixel clock, the only clock.
REQ-006 SHALL have port I_rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 SHALL have port I_vsync, input, 1 bit: camera VSYNC, active high.
REQ-008 SHALL have port I_href, input, 1 bit: camera HREF, active high, one beat per clock.
REQ-009 SHALL have port I_data, input, IN_W bits: camera pixel data; byte = I_data[IN_W-1 -: 8].
REQ-010 SHALL have port I_en, input, 1 bit: capture enable.
REQ-011 SHALL have port I_mode, input, 2 bits: 0 = RGB565 two-beat, 1 = RAW grey, 2 = RGB565 byte-swapped, 3 = same as 1.
REQ-012 SHALL have port I_skip, input, 4 bits: number of frames dropped after each passed frame.
REQ-013 SHALL have ports I_h_start, I_h_res, I_v_start and I_v_res, input, CNT_W bits each: crop window in pixels and lines.
REQ-014 SHALL have port O_vs_n, output, 1 bit: frame sync, active low.
REQ-015 SHALL have port O_de, output, 1 bit: output pixel valid.
REQ-016 SHALL have port O_data, output, 16 bits: RGB565 pixel.
REQ-017 SHALL have port O_frame_cnt, output, FCNT_W bits: count of passed frames.
REQ-018 SHALL have port O_sync_err, output, 1 bit: sticky odd-beat line error.

Function
REQ-019 SHALL detect a frame start (FS) at a clock edge where I_vsync=1 and the registered previous I_vsync=0.
REQ-020 At FS, SHALL latch I_mode, I_en, I_skip and all four crop inputs; these inputs SHALL be ignored at all other times.
REQ-021 Frame pass/drop at FS: if skip_cnt==0 and the latched I_en=1, the frame passes and skip_cnt reloads to I_skip; otherwise the frame drops and skip_cnt decrements, saturating at 0.
REQ-022 O_vs_n SHALL be registered as ~(I_vsync & pass), using the new pass decision at FS.
REQ-023 O_vs_n latency SHALL be 1 clock from the I_vsync edge.
REQ-024 In a dropped frame, O_vs_n SHALL stay 1 and O_de SHALL stay 0.
REQ-025 Beats SHALL be accepted only while I_href=1 and I_vsync=0.
REQ-026 The beat-phase bit SHALL clear whenever I_href=0.
REQ-027 Mode 0: beat A (phase 0) is stored; on beat B (phase 1), O_data = {A_byte, B_byte}.
REQ-028 Mode 2: O_data = {B_byte, A_byte}.
REQ-029 Modes 1/3: every beat forms a pixel; with p = I_data[IN_W-1:IN_W-6], O_data = {p[5:1], p, p[5:1]}.
REQ-030 Pixel x counter SHALL increment per formed pixel, clear on the I_href falling edge, and clear at FS.
REQ-031 Line y counter SHALL increment on each I_href falling edge and clear at FS.
REQ-032 Both position counters SHALL saturate at all-ones, with no wrap.
REQ-033 A formed pixel SHALL be emitted only if pass=1, h_start <= x < h_start+h_res, and v_start <= y < v_start+v_res.
REQ-034 Window sums SHALL be computed in CNT_W+1 bits, so they never overflow.
REQ-035 h_res=0 or v_res=0 SHALL produce no O_de in that frame.
REQ-036 O_de/O_data latency SHALL be 1 clock after the completing beat's edge.
REQ-037 O_data SHALL hold its last value while O_de=0.
REQ-038 O_de SHALL be 1 for at most one cycle per pixel in modes 0/2, i.e. every other cycle at most.
REQ-039 Odd-beat error: an I_href falling edge with phase=1 in mode 0/2 SHALL set O_sync_err, discard the half pixel, and still advance y.
REQ-040 O_sync_err SHALL clear only at the FS of a passed frame.
REQ-041 O_frame_cnt SHALL increment at each passed FS and wrap modulo 2^FCNT_W.
REQ-042 FS coinciding with I_href=1 SHALL behave as FS: counters clear, and the beat is ignored because I_vsync=1.
REQ-043 I_vsync falling while I_href=1 SHALL take no special action.

Reset
REQ-044 On I_rst_n=0, asynchronously: O_vs_n=1, O_de=0, O_data=0, O_frame_cnt=0, O_sync_err=0.
REQ-045 On I_rst_n=0, asynchronously: skip_cnt=0, x=0, y=0, phase=0, latched mode=0, pass=0, previous-vsync=0.
REQ-046 After reset release, no pixel SHALL be emitted before the first FS.
REQ-047 Reset mid-line or mid-frame SHALL discard the partial frame.

Verification
REQ-048 Scenario: mode 0, IN_W=10, window 0/4/0/2, 2 lines of 4 pixels, beats 0xF8<<2, 0x1F<<2 -> 8 O_de pulses, each O_data=16'hF81F, each 1 clock after beat B; O_frame_cnt=1.
REQ-049 Scenario: mode 2, same beats -> O_data=16'h1FF8; mode 1 with I_data=10'h3FF -> O_data=16'hFFFF on every beat.
REQ-050 Scenario: I_skip=2, 6 frames -> O_vs_n low only in frames 1 and 4; O_frame_cnt=2; no O_de in dropped frames.
REQ-051 Scenario: crop h_start=2, h_res=3, v_start=1, v_res=1, 4 lines of 8 pixels -> exactly 3 O_de, all on line 1, pixels x=2..4.
REQ-052 Scenario: line of 5 beats in mode 0 -> 2 pixels and O_sync_err=1; the next passed FS clears it; I_mode changed mid-frame has no effect until FS.
REQ-053 Scenario: I_rst_n pulsed low mid-line -> outputs return to reset values immediately; no O_de until the next FS.
